// File: rtl/adma_sequencer.sv
// ADMA descriptor sequencer: walks a chain of 96-bit descriptors, launching data transfers.
// Latency: start->fetch_req 1 cycle, fetch_ack->xfer_start 1 cycle; stalls on fetch_ack/xfer_done.
module adma_sequencer #(
  parameter int MAX_LINKS  = 8,
  parameter int DESC_BYTES = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] desc_base,
  input  logic        stop,
  output logic        fetch_req,
  output logic [63:0] fetch_addr,
  input  logic        fetch_ack,
  input  logic [95:0] fetch_desc,
  output logic        xfer_start,
  output logic [63:0] xfer_addr,
  output logic [16:0] xfer_len,
  input  logic        xfer_done,
  output logic        busy,
  output logic        done,
  output logic        irq,
  output logic        error,
  output logic        aborted,
  output logic [15:0] desc_count
);

  localparam int LW = $clog2(MAX_LINKS + 1);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, XFER, FINISH, FAULT} state_t;

  state_t        state, state_nx;
  logic [63:0]   desc_ptr;
  logic [95:0]   desc_q;
  logic [LW-1:0] link_cnt, link_inc;

  logic        d_valid, d_end, d_int;
  logic [1:0]  d_act;
  logic [15:0] d_len;
  logic [63:0] d_addr;
  logic [16:0] len_full;
  logic        start_ok, ack_ok, complete, link_take, link_clr, set_err;
  logic        unused_desc;

  assign d_valid     = desc_q[0];
  assign d_end       = desc_q[1];
  assign d_int       = desc_q[2];
  assign d_act       = desc_q[5:4];
  assign d_len       = desc_q[31:16];
  assign d_addr      = desc_q[95:32];
  assign unused_desc = ^{desc_q[15:6], desc_q[3]};
  assign link_inc    = link_cnt + LW'(1);
  // A zero length field encodes the full 64 KiB transfer.
  assign len_full    = (d_len == 16'd0) ? 17'h10000 : {1'b0, d_len};

  assign busy       = (state != IDLE);
  assign fetch_req  = (state == FETCH);
  assign fetch_addr = fetch_req ? desc_ptr : 64'd0;
  assign xfer_addr  = (xfer_start || state == XFER) ? d_addr : 64'd0;
  assign xfer_len   = (xfer_start || state == XFER) ? len_full : 17'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    start_ok   = 1'b0;
    ack_ok     = 1'b0;
    complete   = 1'b0;
    link_take  = 1'b0;
    link_clr   = 1'b0;
    set_err    = 1'b0;
    xfer_start = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) begin
        start_ok = 1'b1;
        state_nx = FETCH;
      end
      FETCH: if (fetch_ack) begin
        ack_ok   = 1'b1;
        state_nx = DECODE;
      end
      DECODE: begin
        if (!d_valid) state_nx = FAULT;
        else if (d_act == 2'b10) begin
          xfer_start = 1'b1;
          link_clr   = 1'b1;
          state_nx   = XFER;
        end else if (d_act == 2'b11) begin
          link_take = 1'b1;
          if (link_inc == LW'(MAX_LINKS)) state_nx = FAULT;
          else if (d_end)                 state_nx = FINISH;
          else                            state_nx = FETCH;
        end else complete = 1'b1;
      end
      XFER:   if (xfer_done) complete = 1'b1;
      FINISH: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      FAULT: begin
        set_err  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (complete) state_nx = d_end ? FINISH : FETCH;
    // Abort wins over any same-cycle completion event.
    if (stop && state != IDLE) begin
      state_nx   = IDLE;
      ack_ok     = 1'b0;
      complete   = 1'b0;
      link_take  = 1'b0;
      link_clr   = 1'b0;
      set_err    = 1'b0;
      xfer_start = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      desc_ptr   <= 64'd0;
      desc_q     <= 96'd0;
      link_cnt   <= '0;
      desc_count <= 16'd0;
      irq        <= 1'b0;
      error      <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      irq     <= complete & d_int;
      aborted <= stop && (state != IDLE);
      if (start_ok) begin
        desc_ptr   <= desc_base;
        desc_count <= 16'd0;
        error      <= 1'b0;
        link_cnt   <= '0;
      end
      if (ack_ok) begin
        desc_q <= fetch_desc;
        if (desc_count != 16'hFFFF) desc_count <= desc_count + 16'd1;
      end
      if (link_take) begin
        desc_ptr <= d_addr;
        link_cnt <= link_inc;
      end
      if (link_clr) link_cnt <= '0;
      if (complete && !d_end) desc_ptr <= desc_ptr + 64'(DESC_BYTES);
      if (set_err) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adma_sequencer.sv
// Directed bench for adma_sequencer: descriptor memory model plus fetch/transfer scoreboards.
module tb_adma_sequencer;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0;
  logic        fetch_ack = 1'b0, xfer_done = 1'b0;
  logic [63:0] desc_base = 64'd0;
  logic [95:0] fetch_desc = 96'd0;
  logic        fetch_req, xfer_start, busy, done, irq, error, aborted;
  logic [63:0] fetch_addr, xfer_addr;
  logic [16:0] xfer_len;
  logic [15:0] desc_count;

  int tests = 0, fails = 0;
  int n_irq, n_done, n_abort, n_cyc, done_lat;

  logic [95:0] mem [logic [63:0]];
  logic [63:0] fq [$];
  logic [80:0] xq [$];

  localparam logic [1:0] NOP = 2'b00, TRAN = 2'b10, LINK = 2'b11;

  adma_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .desc_base(desc_base), .stop(stop),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_desc(fetch_desc),
    .xfer_start(xfer_start), .xfer_addr(xfer_addr), .xfer_len(xfer_len), .xfer_done(xfer_done),
    .busy(busy), .done(done), .irq(irq), .error(error), .aborted(aborted), .desc_count(desc_count)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] mkd(input logic v, input logic e, input logic i,
                                      input logic [1:0] act, input logic [15:0] len,
                                      input logic [63:0] addr);
    return {addr, len, 10'b0, act, 1'b0, i, e, v};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {busy, fetch_req, xfer_start, done, irq, error, aborted, desc_count}, 128'd0);
    chk({tag, "_addr"}, {fetch_addr, xfer_addr}, 128'd0);
    chk({tag, "_len"}, xfer_len, 128'd0);
  endtask

  task automatic do_start(input logic [63:0] base);
    desc_base = base;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_fetch_req", fetch_req, 1);
    chk("start_err_clr", error, 0);
    chk("start_cnt_clr", desc_count, 0);
  endtask

  // Plays memory and data mover until the sequencer goes idle.
  task automatic run_list(input int max_cyc, input bit stop_on_xd,
                          output int ni, output int nd, output int na, output int nc,
                          output int lat);
    int xwait = 0, last_xd = -100;
    bit prev_ack = 1'b0;
    logic [80:0] cur_x = '0;
    ni = 0; nd = 0; na = 0; nc = 0; lat = -1;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      nc = cyc;
      if (irq) ni++;
      if (aborted) na++;
      if (done) begin
        nd++;
        lat = cyc - last_xd;
      end
      if (!busy) break;
      stop = 1'b0;
      xfer_done = 1'b0;
      if (xwait > 0) begin
        xwait--;
        if (xwait == 0) begin
          chk("xfer_hold", {xfer_addr, xfer_len}, cur_x);
          xfer_done = 1'b1;
          last_xd = cyc;
          if (stop_on_xd) stop = 1'b1;
        end
      end
      if (xfer_start) begin
        chk("ack_to_xfer", prev_ack, 1);
        if (xq.size() == 0) chk("xfer_unexpected", xq.size(), 1);
        else begin
          cur_x = xq.pop_front();
          chk("xfer_cmd", {xfer_addr, xfer_len}, cur_x);
        end
        xwait = 2;
      end
      prev_ack = 1'b0;
      fetch_ack = 1'b0;
      if (fetch_req) begin
        if (fq.size() == 0) chk("fetch_unexpected", fq.size(), 1);
        else chk("fetch_addr", fetch_addr, fq.pop_front());
        fetch_desc = mem[fetch_addr];
        fetch_ack = 1'b1;
        prev_ack = 1'b1;
      end
      @(negedge clk);
    end
    stop = 1'b0;
    xfer_done = 1'b0;
    fetch_ack = 1'b0;
    chk("idle_at_end", busy, 0);
    chk("fetch_q_empty", fq.size(), 0);
    chk("xfer_q_empty", xq.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single transfer with end+int.
    mem[64'h1000] = mkd(1, 1, 1, TRAN, 16'h0200, 64'h8000);
    fq.push_back(64'h1000);
    xq.push_back({64'h8000, 17'h00200});
    do_start(64'h1000);
    run_list(200, 0, n_irq, n_done, n_abort, n_cyc, done_lat);
    chk("t1_irq", n_irq, 1);
    chk("t1_done", n_done, 1);
    chk("t1_done_lat", done_lat, 1);
    chk("t1_count", desc_count, 1);
    chk("t1_err", error, 0);

    // Sequential stride and zero-length encoding.
    mem[64'h2000] = mkd(1, 0, 0, TRAN, 16'h0010, 64'hA000);
    mem[64'h200C] = mkd(1, 1, 0, TRAN, 16'h0000, 64'hB000);
    fq.push_back(64'h2000);
    fq.push_back(64'h200C);
    xq.push_back({64'hA000, 17'h00010});
    xq.push_back({64'hB000, 17'h10000});
    do_start(64'h2000);
    run_list(200, 0, n_irq, n_done, n_abort, n_cyc, done_lat);
    chk("t2_irq", n_irq, 0);
    chk("t2_done", n_done, 1);
    chk("t2_count", desc_count, 2);

    // Link then transfer.
    mem[64'h3000] = mkd(1, 0, 0, LINK, 16'h0000, 64'h4000);
    mem[64'h4000] = mkd(1, 1, 0, TRAN, 16'h0004, 64'hC000);
    fq.push_back(64'h3000);
    fq.push_back(64'h4000);
    xq.push_back({64'hC000, 17'h00004});
    do_start(64'h3000);
    run_list(200, 0, n_irq, n_done, n_abort, n_cyc, done_lat);
    chk("t3_done", n_done, 1);
    chk("t3_count", desc_count, 2);
    chk("t3_err", error, 0);

    // Eight consecutive links trip the chain limit.
    for (int i = 0; i < 8; i++) begin
      mem[64'h10000 + 64'(i) * 64'h100] = mkd(1, 0, 0, LINK, 16'h0, 64'h10000 + 64'(i + 1) * 64'h100);
      fq.push_back(64'h10000 + 64'(i) * 64'h100);
    end
    do_start(64'h10000);
    run_list(400, 0, n_irq, n_done, n_abort, n_cyc, done_lat);
    chk("t4_err", error, 1);
    chk("t4_done", n_done, 0);
    chk("t4_count", desc_count, 8);

    // Invalid descriptor faults two cycles after the ack.
    mem[64'h5000] = 96'd0;
    fq.push_back(64'h5000);
    do_start(64'h5000);
    run_list(200, 0, n_irq, n_done, n_abort, n_cyc, done_lat);
    chk("t5_err", error, 1);
    chk("t5_fault_lat", n_cyc, 3);
    chk("t5_irq", n_irq, 0);

    // Nop with end+int completes without a transfer; start clears error.
    mem[64'h6000] = mkd(1, 1, 1, NOP, 16'h0, 64'h0);
    fq.push_back(64'h6000);
    do_start(64'h6000);
    run_list(200, 0, n_irq, n_done, n_abort, n_cyc, done_lat);
    chk("t6_irq", n_irq, 1);
    chk("t6_done", n_done, 1);

    // Stop coincident with xfer_done.
    mem[64'h7000] = mkd(1, 1, 1, TRAN, 16'h0008, 64'hD000);
    fq.push_back(64'h7000);
    xq.push_back({64'hD000, 17'h00008});
    do_start(64'h7000);
    run_list(200, 1, n_irq, n_done, n_abort, n_cyc, done_lat);
    chk("t7_abort", n_abort, 1);
    chk("t7_irq", n_irq, 0);
    chk("t7_done", n_done, 0);

    // Reset mid-transfer clears everything asynchronously.
    mem[64'h8000] = mkd(1, 1, 0, TRAN, 16'h0040, 64'hE000);
    do_start(64'h8000);
    fetch_desc = mem[64'h8000];
    fetch_ack = 1'b1;
    @(negedge clk);
    fetch_ack = 1'b0;
    chk("t8_xfer_start", xfer_start, 1);
    @(negedge clk);
    chk("t8_in_xfer", {xfer_addr, xfer_len}, {64'hE000, 17'h00040});
    #2 reset = 1'b0;
    #1 check_zero("t8_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Fresh list after reset.
    fq.push_back(64'h1000);
    xq.push_back({64'h8000, 17'h00200});
    do_start(64'h1000);
    run_list(200, 0, n_irq, n_done, n_abort, n_cyc, done_lat);
    chk("t9_done", n_done, 1);
    chk("t9_count", desc_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
